// File: rtl/phoenix_input_buffer.sv
`default_nettype none
// ============================================================================
// Module   : phoenix_input_buffer
// Purpose  : Per-port input buffer of the Phoenix NoC router. Circular FIFO
//            that raises a routing request when a header is at its head and,
//            once granted, streams exactly one packet (header, size, payload)
//            to the crossbar before releasing its path.
// Revision : 1.0 - initial release
// ============================================================================
module phoenix_input_buffer #(
  parameter int FLIT_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx,
  input  logic [FLIT_WIDTH-1:0] data_in,
  output logic                  credit_o,
  output logic                  h,
  input  logic                  ack_h,
  output logic                  data_av,
  output logic [FLIT_WIDTH-1:0] data_out,
  input  logic                  data_ack,
  output logic                  sender
);

  localparam int              C_PW    = $clog2(DEPTH);
  localparam int              C_CW    = C_PW + 1;
  localparam logic [C_CW-1:0] C_FULL  = C_CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SEND = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PH_HEADER  = 2'd0,
    PH_SIZE    = 2'd1,
    PH_PAYLOAD = 2'd2
  } phase_t;

  state_t                r_state;
  state_t                w_state_nxt;
  phase_t                r_phase;
  phase_t                w_phase_nxt;
  logic [FLIT_WIDTH-1:0] r_remaining;
  logic [FLIT_WIDTH-1:0] w_remaining_nxt;

  logic [FLIT_WIDTH-1:0] r_mem [DEPTH];
  logic [C_PW-1:0]       r_head;
  logic [C_PW-1:0]       r_tail;
  logic [C_CW-1:0]       r_count;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_sending;
  logic                  w_empty;

  // A full FIFO refuses the flit even if a pop frees a slot this same cycle.
  assign credit_o  = (r_count != C_FULL);
  assign w_empty   = (r_count == '0);
  assign w_push    = rx & credit_o;
  assign w_sending = (r_state == S_SEND);
  assign data_av   = w_sending & ~w_empty;
  assign w_pop     = data_av & data_ack;
  assign data_out  = r_mem[r_head];
  assign h         = (r_state == S_REQ);
  assign sender    = w_sending;

  // Flit storage; contents need no reset since count gates visibility.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_tail] <= data_in;
    end
  end

  // Head/tail pointers wrap naturally (power-of-two depth); count tracks occupancy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + C_PW'(1);
      if (w_pop)  r_head <= r_head + C_PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CW'(1);
        2'b01:   r_count <= r_count - C_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Packet-tracking state: FSM state, flit phase and remaining payload count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_phase     <= PH_HEADER;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  // Next-state logic: request when data is buffered, send one packet per grant.
  always_comb begin
    w_state_nxt     = r_state;
    w_phase_nxt     = r_phase;
    w_remaining_nxt = r_remaining;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (ack_h) begin
          w_state_nxt = S_SEND;
          w_phase_nxt = PH_HEADER;
        end
      end
      S_SEND: begin
        if (w_pop) begin
          case (r_phase)
            PH_HEADER: w_phase_nxt = PH_SIZE;
            PH_SIZE: begin
              // The size flit itself carries the payload length.
              w_remaining_nxt = data_out;
              if (data_out == '0) begin
                w_state_nxt = S_IDLE;
              end else begin
                w_phase_nxt = PH_PAYLOAD;
              end
            end
            PH_PAYLOAD: begin
              w_remaining_nxt = r_remaining - FLIT_WIDTH'(1);
              if (r_remaining == FLIT_WIDTH'(1)) w_state_nxt = S_IDLE;
            end
            default: w_phase_nxt = PH_HEADER;
          endcase
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_phoenix_input_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_phoenix_input_buffer
// Purpose  : Self-checking bench for phoenix_input_buffer (DEPTH=4): cycle
//            vector table, hand-written corner sequences and a randomized
//            packet-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phoenix_input_buffer;

  localparam int FW    = 16;
  localparam int DEPTH = 4;

  logic          clock;
  logic          reset;
  logic          rx;
  logic [FW-1:0] data_in;
  logic          credit_o;
  logic          h;
  logic          ack_h;
  logic          data_av;
  logic [FW-1:0] data_out;
  logic          data_ack;
  logic          sender;

  int checks   = 0;
  int failures = 0;

  logic [FW-1:0] src[$];
  int            pkt_lens[$];

  phoenix_input_buffer #(.FLIT_WIDTH(FW), .DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .rx       (rx),
    .data_in  (data_in),
    .credit_o (credit_o),
    .h        (h),
    .ack_h    (ack_h),
    .data_av  (data_av),
    .data_out (data_out),
    .data_ack (data_ack),
    .sender   (sender)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  typedef struct {
    logic          rx;
    logic [FW-1:0] din;
    logic          ack;
    logic          dack;
    logic          e_credit;
    logic          e_h;
    logic          e_av;
    logic          e_snd;
    logic          chk_dout;
    logic [FW-1:0] e_dout;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [FW-1:0] d, input logic a,
                              input logic da, input logic ec, input logic eh,
                              input logic eav, input logic es, input logic cd,
                              input logic [FW-1:0] ed);
    vec_t v;
    v.rx = r; v.din = d; v.ack = a; v.dack = da;
    v.e_credit = ec; v.e_h = eh; v.e_av = eav; v.e_snd = es;
    v.chk_dout = cd; v.e_dout = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [FW-1:0] d, input logic a, input logic da);
    rx = r; data_in = d; ack_h = a; data_ack = da;
    #1;
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  task automatic add_packet(input int n);
    src.push_back(FW'($urandom));
    src.push_back(FW'(n));
    for (int i = 0; i < n; i++) src.push_back(FW'($urandom));
    pkt_lens.push_back(n + 2);
  endtask

  // Packet-level reference: an ordered flit queue plus per-grant length accounting.
  task automatic run_model(input bit fixed_mode, input int budget);
    logic [FW-1:0] mq[$];
    int  n_in_pkt   = 0;
    bit  prev_snd   = 1'b0;
    bit  grant_prev = 1'b0;
    bit  tog        = 1'b0;
    bit  done       = 1'b0;
    int  cyc_n      = 0;
    while (!done) begin
      rx      = (src.size() > 0) && (fixed_mode || ($urandom_range(0, 3) != 0));
      data_in = '0;
      if (src.size() > 0) data_in = src[0];
      if (fixed_mode) ack_h = h;
      else            ack_h = h ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      if (fixed_mode) begin
        tog      = ~tog;
        data_ack = tog;
      end else begin
        data_ack = ($urandom_range(0, 9) < 6);
      end
      #1;
      chk("m_credit", credit_o, (mq.size() != DEPTH));
      chk("m_data_av", data_av, sender && (mq.size() != 0));
      chk("m_h_and_sender", h && sender, 1'b0);
      chk("m_grant_start", sender && !prev_snd, grant_prev);
      if (data_av) chk("m_data_out", data_out, mq[0]);
      if (sender == 1'b0 && prev_snd == 1'b1) begin
        if (pkt_lens.size() > 0) begin
          chk("m_pkt_len", n_in_pkt, pkt_lens[0]);
          void'(pkt_lens.pop_front());
        end else begin
          chk("m_unexpected_pkt", 1, 0);
        end
        n_in_pkt = 0;
      end
      if (data_av && data_ack && mq.size() > 0) begin
        void'(mq.pop_front());
        n_in_pkt++;
        if (pkt_lens.size() > 0) chk("m_pkt_overrun", (n_in_pkt <= pkt_lens[0]), 1);
      end
      if (rx && credit_o && src.size() > 0) mq.push_back(src.pop_front());
      prev_snd   = sender;
      grant_prev = h && ack_h;
      if (src.size() == 0 && mq.size() == 0 && !sender && pkt_lens.size() == 0) begin
        done = 1'b1;
      end else begin
        cyc_n++;
        if (cyc_n > budget) begin
          chk("m_timeout", 1, 0);
          src.delete();
          pkt_lens.delete();
          done = 1'b1;
        end
      end
      adv();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    // Single 4-flit packet, ack_h three cycles after h rises, data_ack held high.
    vecs.push_back(mk(1, 16'h0011, 0, 1, 1, 0, 0, 0, 0, 16'h0));
    vecs.push_back(mk(1, 16'h0002, 0, 1, 1, 0, 0, 0, 0, 16'h0));
    vecs.push_back(mk(1, 16'hAAAA, 0, 1, 1, 1, 0, 0, 0, 16'h0));
    vecs.push_back(mk(1, 16'hBBBB, 0, 1, 1, 1, 0, 0, 0, 16'h0));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 1, 0, 0, 0, 16'h0));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 1, 0, 0, 0, 16'h0));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 0, 1, 1, 1, 16'h0011));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 1, 0, 1, 1, 1, 16'h0002));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 1, 0, 1, 1, 1, 16'hAAAA));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 1, 0, 1, 1, 1, 16'hBBBB));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 1, 0, 0, 0, 0, 16'h0));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 1, 0, 0, 0, 0, 16'h0));
    // Zero-payload packet followed by a 1-payload packet pushed during send.
    vecs.push_back(mk(1, 16'h0022, 0, 1, 1, 0, 0, 0, 0, 16'h0));
    vecs.push_back(mk(1, 16'h0000, 0, 1, 1, 0, 0, 0, 0, 16'h0));
    vecs.push_back(mk(1, 16'h0033, 1, 1, 1, 1, 0, 0, 0, 16'h0));
    vecs.push_back(mk(1, 16'h0001, 0, 1, 1, 0, 1, 1, 1, 16'h0022));
    vecs.push_back(mk(1, 16'hCCCC, 0, 1, 1, 0, 1, 1, 1, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 1, 0, 0, 0, 0, 16'h0));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 1, 1, 0, 0, 0, 16'h0));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 1, 0, 1, 1, 1, 16'h0033));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 1, 0, 1, 1, 1, 16'h0001));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 1, 0, 1, 1, 1, 16'hCCCC));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 1, 0, 0, 0, 0, 16'h0));

    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_h", h, 0);
    chk("rst_data_av", data_av, 0);
    chk("rst_sender", sender, 0);
    chk("rst_credit", credit_o, 1);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rx, vecs[i].din, vecs[i].ack, vecs[i].dack);
      chk($sformatf("v%0d_credit", i), credit_o, vecs[i].e_credit);
      chk($sformatf("v%0d_h", i), h, vecs[i].e_h);
      chk($sformatf("v%0d_data_av", i), data_av, vecs[i].e_av);
      chk($sformatf("v%0d_sender", i), sender, vecs[i].e_snd);
      if (vecs[i].chk_dout) chk($sformatf("v%0d_data_out", i), data_out, vecs[i].e_dout);
      adv();
    end

    // Asynchronous reset between edges while requesting.
    drive(1'b1, 16'h0101, 1'b0, 1'b0); adv();
    drive(1'b0, '0, 1'b0, 1'b0); adv();
    chk("ar_pre_h", h, 1);
    #1 reset = 1'b0;
    #1;
    chk("ar_h", h, 0);
    chk("ar_data_av", data_av, 0);
    chk("ar_sender", sender, 0);
    chk("ar_credit", credit_o, 1);
    adv(); adv();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b0, 1'b0);
      chk("ar_idle_h", h, 0);
      chk("ar_idle_sender", sender, 0);
      adv();
    end

    // Full FIFO: fifth flit refused, and refused again while a pop frees a slot.
    drive(1'b1, 16'h0044, 0, 0); chk("f_credit0", credit_o, 1); adv();
    drive(1'b1, 16'h0003, 0, 0); chk("f_credit1", credit_o, 1); adv();
    drive(1'b1, 16'h0001, 0, 0); chk("f_credit2", credit_o, 1); adv();
    drive(1'b1, 16'h0002, 0, 0); chk("f_credit3", credit_o, 1); adv();
    drive(1'b1, 16'h0003, 0, 0); chk("f_full_credit", credit_o, 0); adv();
    drive(1'b0, '0, 1, 0);       chk("f_h", h, 1); adv();
    drive(1'b1, 16'h0003, 0, 1);
    chk("f_full_pop_credit", credit_o, 0);
    chk("f_hdr", data_out, 16'h0044);
    chk("f_hdr_av", data_av, 1);
    adv();
    drive(1'b1, 16'h0003, 0, 1);
    chk("f_credit_back", credit_o, 1);
    chk("f_size", data_out, 16'h0003);
    adv();
    drive(1'b0, '0, 0, 1); chk("f_p1", data_out, 16'h0001); adv();
    drive(1'b0, '0, 0, 1); chk("f_p2", data_out, 16'h0002); adv();
    drive(1'b0, '0, 0, 1); chk("f_p3", data_out, 16'h0003); chk("f_p3_snd", sender, 1); adv();
    drive(1'b0, '0, 0, 1);
    chk("f_end_sender", sender, 0);
    chk("f_end_av", data_av, 0);
    adv();
    drive(1'b0, '0, 0, 0); chk("f_end_h", h, 0); adv();

    // Wrap-around: 8-flit packet through a 4-deep FIFO, data_ack toggling.
    add_packet(6);
    run_model(1'b1, 200);

    // Reset after two payload pops of an N=5 packet.
    drive(1'b1, 16'h0055, 0, 0); adv();
    drive(1'b1, 16'h0005, 0, 0); adv();
    drive(1'b1, 16'h1001, 1, 0); chk("rp_h", h, 1); adv();
    drive(1'b1, 16'h1002, 0, 1); chk("rp_hdr", data_out, 16'h0055); adv();
    drive(1'b1, 16'h1003, 0, 1); chk("rp_size", data_out, 16'h0005); adv();
    drive(1'b0, '0, 0, 1);       chk("rp_p1", data_out, 16'h1001); adv();
    drive(1'b0, '0, 0, 1);       chk("rp_p2", data_out, 16'h1002); adv();
    drive(1'b0, '0, 0, 0);
    chk("rp_pre_sender", sender, 1);
    chk("rp_pre_av", data_av, 1);
    #1 reset = 1'b0;
    #1;
    chk("rp_sender", sender, 0);
    chk("rp_av", data_av, 0);
    chk("rp_credit", credit_o, 1);
    adv();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 0, 1);
      chk("rp_idle_h", h, 0);
      chk("rp_idle_av", data_av, 0);
      adv();
    end
    src.push_back(16'h0066); src.push_back(16'h0002);
    src.push_back(16'h8888); src.push_back(16'h9999);
    pkt_lens.push_back(4);
    run_model(1'b1, 200);

    // Randomized packet stream against the reference model.
    for (int i = 0; i < 40; i++) add_packet($urandom_range(0, 5));
    run_model(1'b0, 5000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/phoenix_input_buffer.md
# phoenix_input_buffer

Per-port input buffer for the Phoenix NoC router, the requesting side of the switch-control round-robin arbiter. It stores incoming flits in a circular FIFO and raises a routing request when a packet header is at the head. After the grant it streams exactly one packet (header, size, payload) to the crossbar, then releases the grant. Five instances sit in each router (E, W, N, S, Local).

## Interface
Parameters:
- FLIT_WIDTH, 16, flit width in bits
- DEPTH, 16, FIFO depth in flits; must be a power of two and at least 2

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- rx  in  1  upstream flit valid
- data_in  in  FLIT_WIDTH  upstream flit
- credit_o  out  1  space available; 1 = a flit offered with rx is accepted this cycle
- h  out  1  routing/arbitration request to switch control
- ack_h  in  1  grant from switch control, one-cycle pulse
- data_av  out  1  flit available to crossbar
- data_out  out  FLIT_WIDTH  flit at FIFO head
- data_ack  in  1  crossbar/downstream consumed the flit
- sender  out  1  1 while this port owns its crossbar path

## Operation
- Packet format:
  - flit 0 is the header;
  - flit 1 is size N, an unsigned value equal to data_in[FLIT_WIDTH-1:0];
  - flits 2..N+1 are payload.
  - N=0 is legal and gives a 2-flit packet.
- FIFO storage:
  - DEPTH x FLIT_WIDTH circular buffer with head and tail pointers of width $clog2(DEPTH); both wrap from DEPTH-1 to 0.
  - Occupancy count has width $clog2(DEPTH)+1.
- Push occurs when rx and credit_o are both 1. credit_o = (count != DEPTH).
- Pop occurs when data_av and data_ack are both 1.
- Push and pop may happen in the same cycle; count is then unchanged.
- When the FIFO is full, credit_o=0 even if a pop occurs in the same cycle, so no push is accepted that cycle.
- data_out always shows the head entry; its value is don't-care when count=0.
- FSM states:
  - IDLE: h=0, sender=0. Go to REQ when count != 0.
  - REQ: h=1. Go to SEND on the edge where ack_h=1; otherwise stay in REQ.
  - SEND: sender=1, data_av = (count != 0).
    - Popping flit 0 sets phase to SIZE.
    - Popping the size flit loads remaining = N. If N=0, go to IDLE.
    - Each payload pop decrements remaining. Popping with remaining=1 goes to IDLE.
- The flit counter/phase register resets to HEADER whenever SEND is entered.
- ack_h is ignored outside REQ.
- data_ack is ignored whenever data_av=0.
- Pushes continue in every state, so the next packet may already be buffered while the current one is sent.
- Reset (asynchronous, mid-operation included):
  - state becomes IDLE; pointers, count, phase and remaining are cleared;
  - any partial packet is discarded;
  - outputs while in reset: h=0, data_av=0, sender=0, credit_o=1, data_out=don't-care.

## Timing
- Push at edge k sets count=1 after edge k. IDLE moves to REQ at edge k+1, so h=1 from edge k+1.
- A flit that arrives while the FSM is in SEND does not raise h until the packet completes and IDLE is re-entered, giving a minimum of 1 idle cycle between packets.
- ack_h=1 sampled at edge g puts the FSM in SEND after g. data_av is combinational, so it can be 1 in the cycle right after g.
- Throughput is one flit per cycle while count != 0 and data_ack=1.
- On the edge that pops the last flit, the FSM returns to IDLE: sender and data_av drop after that edge. If count != 0, h rises one edge later.
- credit_o reflects the current count, with no extra latency.

## Test plan
- Reset: assert reset mid-cycle with no clock -> h=0, data_av=0, sender=0, credit_o=1 immediately. Release reset and push nothing -> FSM stays in IDLE.
- Single packet: push 0x0011, 0x0002, 0xAAAA, 0xBBBB; pulse ack_h 3 cycles after h rises; hold data_ack=1 -> data_out sequence 0x0011, 0x0002, 0xAAAA, 0xBBBB on 4 consecutive cycles; sender=0 after the 4th pop; count=0.
- Zero-payload packet: push 0x0022, 0x0000, then 0x0033, 0x0001, 0xCCCC -> first packet sends 2 flits and returns to IDLE; h rises again 1 cycle later; second packet sends 3 flits.
- Full/backpressure with DEPTH=4: push 5 flits with data_ack=0 -> credit_o=0 after the 4th push and the 5th flit is not stored. Then with the FIFO full, pop one flit while rx=1 -> that flit is not accepted; credit_o returns to 1 on the next cycle.
- Wrap-around with DEPTH=4: stream a 1+1+6-flit packet with data_ack toggling 1/0 -> all 8 flits exit in order with pointers wrapping; data_av=0 whenever count=0.
- Reset mid-packet: assert reset after 2 payload pops of an N=5 packet -> state IDLE and FIFO empty. A new packet pushed afterwards is sent correctly, starting from its header.
